// File: rtl/posit_io_sequencer_pkg.sv
// posit_io_pkg: shared state encoding, NaR constant and timeout limit for the posit I/O sequencer.
// Contents:
//   LOAD_A..OUT  sequencer state codes
//   TMO_LIMIT    WAIT cycle count at which the optional timeout fires
//   nar(n)       NaR bit pattern (MSB set, rest clear) of an n-bit posit
package posit_io_pkg;
    localparam logic [2:0] LOAD_A = 3'd0;
    localparam logic [2:0] LOAD_B = 3'd1;
    localparam logic [2:0] START  = 3'd2;
    localparam logic [2:0] WAIT   = 3'd3;
    localparam logic [2:0] OUT    = 3'd4;
    localparam logic [7:0] TMO_LIMIT = 8'd255;
    function automatic logic [63:0] nar(input int n);
        return 64'd1 << (n - 1);
    endfunction
endpackage

// File: rtl/posit_io_sequencer_if.sv
// posit_io_sequencer_if: pin-side and core-side signals of the posit I/O sequencer.
// Signals:
//   ena, byte_in, byte_stb, op_sel         tester inputs
//   core_a, core_b, core_op, core_start    operands and start towards the core
//   core_done, core_result                 completion and result from the core
//   byte_out, byte_ack, busy, result_valid, err   status back to the tester
// Modports: master = tester/core side, slave = sequencer.
interface posit_io_sequencer_if #(parameter int N = 16);
    logic         ena;
    logic [7:0]   byte_in;
    logic         byte_stb;
    logic [1:0]   op_sel;
    logic [N-1:0] core_a;
    logic [N-1:0] core_b;
    logic [1:0]   core_op;
    logic         core_start;
    logic         core_done;
    logic [N-1:0] core_result;
    logic [7:0]   byte_out;
    logic         byte_ack;
    logic         busy;
    logic         result_valid;
    logic         err;
    modport master (
        output ena, byte_in, byte_stb, op_sel, core_done, core_result,
        input  core_a, core_b, core_op, core_start, byte_out, byte_ack, busy, result_valid, err
    );
    modport slave (
        input  ena, byte_in, byte_stb, op_sel, core_done, core_result,
        output core_a, core_b, core_op, core_start, byte_out, byte_ack, busy, result_valid, err
    );
endinterface

// File: rtl/posit_io_sequencer_strobe_edge_det.sv
// strobe_edge_det: rising-edge detector for the tester strobe, frozen while ena_i is low.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   ena_i       enable; the history register only updates while high
//   stb_i       strobe, synchronous to clk
//   rise_o      high while stb_i is high and was low at the last enabled edge
module strobe_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic ena_i,
    input  logic stb_i,
    output logic rise_o
);
    logic stb_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) stb_q <= 1'b0;
        else if (ena_i) stb_q <= stb_i;
    // A rise arriving while disabled stays pending until ena_i returns.
    assign rise_o = stb_i & ~stb_q;
endmodule

// File: rtl/posit_io_sequencer.sv
// posit_io_sequencer: byte-serial operand loader / result unloader between TinyTapeout pins and a posit core.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         posit_io_sequencer_if.slave (tester pins and core handshake)
// Build option: POSIT_SEQ_TIMEOUT_EN adds a WAIT timeout that returns NaR and raises err.
module posit_io_sequencer
    import posit_io_pkg::*;
#(
    parameter int N = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    posit_io_sequencer_if.slave bus
);
    localparam int NB = N / 8;
    localparam int IW = NB > 1 ? $clog2(NB) : 1;
    localparam logic [IW-1:0] LAST = IW'(NB - 1);
    logic [2:0]    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [N-1:0]  a_q, a_d, b_q, b_d, res_q, res_d;
    logic [1:0]    op_q, op_d;
    logic          ack_q, ack_d;
    logic          rise, accept, last;
`ifdef POSIT_SEQ_TIMEOUT_EN
    localparam logic [N-1:0] NAR = N'(nar(N));
    logic [7:0] tmo_q, tmo_d;
    logic       err_q, err_d;
`endif
    strobe_edge_det u_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena_i  (bus.ena),
        .stb_i  (bus.byte_stb),
        .rise_o (rise)
    );
    assign last   = idx_q == LAST;
    // Strobes during START/WAIT are dropped entirely.
    assign accept = rise & (state_q == LOAD_A || state_q == LOAD_B || state_q == OUT);
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        ack_d   = ack_q;
`ifdef POSIT_SEQ_TIMEOUT_EN
        tmo_d   = tmo_q;
        err_d   = err_q;
`endif
        if (accept) begin
            ack_d = ~ack_q;
            idx_d = last ? '0 : idx_q + 1'b1;
        end
        if (accept && state_q == LOAD_A) begin
            a_d[8*idx_q +: 8] = bus.byte_in;
            if (last) state_d = LOAD_B;
        end
        if (accept && state_q == LOAD_B) begin
            b_d[8*idx_q +: 8] = bus.byte_in;
            if (last) begin
                op_d    = bus.op_sel;
                state_d = START;
            end
        end
        if (accept && state_q == OUT && last) state_d = LOAD_A;
        if (state_q == START) begin
            state_d = WAIT;
`ifdef POSIT_SEQ_TIMEOUT_EN
            tmo_d   = '0;
            err_d   = 1'b0;
`endif
        end
        // A done on the expiry cycle wins over the timeout.
        if (state_q == WAIT && bus.core_done) begin
            res_d   = bus.core_result;
            idx_d   = '0;
            state_d = OUT;
        end
`ifdef POSIT_SEQ_TIMEOUT_EN
        else if (state_q == WAIT && tmo_q == TMO_LIMIT) begin
            res_d   = NAR;
            err_d   = 1'b1;
            idx_d   = '0;
            state_d = OUT;
        end
        else if (state_q == WAIT) tmo_d = tmo_q + 1'b1;
`endif
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD_A;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            ack_q   <= 1'b0;
`ifdef POSIT_SEQ_TIMEOUT_EN
            tmo_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else if (bus.ena) begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            ack_q   <= ack_d;
`ifdef POSIT_SEQ_TIMEOUT_EN
            tmo_q   <= tmo_d;
            err_q   <= err_d;
`endif
        end
    end
    assign bus.core_a       = a_q;
    assign bus.core_b       = b_q;
    assign bus.core_op      = op_q;
    assign bus.core_start   = state_q == START;
    assign bus.busy         = state_q == START || state_q == WAIT;
    assign bus.result_valid = state_q == OUT;
    assign bus.byte_out     = state_q == OUT ? res_q[8*idx_q +: 8] : 8'h00;
    assign bus.byte_ack     = ack_q;
`ifdef POSIT_SEQ_TIMEOUT_EN
    assign bus.err          = err_q;
`else
    assign bus.err          = 1'b0;
`endif
endmodule

// File: doc/posit_io_sequencer.md
# posit_io_sequencer

Byte-wide operand loader and result unloader between the TinyTapeout pin interface of `tt_um_afasolino` and the posit arithmetic core. It accepts two N-bit posit operands byte by byte from `ui_in`, then pulses the core start and waits for the core to finish. It then presents the N-bit result one byte at a time on `uo_out`. All transfers are paced by a slow tester-driven strobe on `uio_in[0]`.

## Interface
- `N`, 16: posit width in bits. Must be a multiple of 8 and at least 8. NB = N/8 bytes per word.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ena`  in  1  design enable. When low, all state and outputs are frozen.
- `byte_in`  in  8  operand byte (`ui_in`).
- `byte_stb`  in  1  transfer strobe (`uio_in[0]`). It acts on its rising edge.
- `op_sel`  in  2  operation code (`uio_in[2:1]`). It is latched together with the last byte of B.
- `core_a`, `core_b`  out  N  operands to the core. They are held stable from `core_start` until the core is done.
- `core_op`  out  2  latched operation code.
- `core_start`  out  1  one-cycle start pulse.
- `core_done`  in  1  core completion, sampled in WAIT only.
- `core_result`  in  N  core result. Valid in the cycle where `core_done` is high.
- `byte_out`  out  8  result byte currently selected (`uo_out`).
- `byte_ack`  out  1  toggles once per accepted strobe edge.
- `busy`  out  1  high in START and WAIT.
- `result_valid`  out  1  high in OUT.
- `err`  out  1  timeout flag (see Configuration).

## Operation
- Edge detection: a register `stb_q` holds the previous `byte_stb`, updated only while `ena` is high. An edge is `byte_stb & ~stb_q`. `byte_stb` is synchronous to `clk`.
- States and transitions:
  - LOAD_A: each edge writes `byte_in` into `core_a[8*idx +: 8]`, least significant byte first, and increments `idx`. After byte NB-1: `idx` resets to 0 and the FSM goes to LOAD_B.
  - LOAD_B: same as LOAD_A but writes `core_b`. On the last byte it also latches `op_sel` into `core_op` and goes to START.
  - START: `core_start` is high for exactly this one cycle. Next state is WAIT.
  - WAIT: if `core_done` is high, capture `core_result` into `res`, set `idx`=0 and go to OUT.
  - OUT: `byte_out` = `res[8*idx +: 8]`. Each edge increments `idx`. The edge that reads byte NB-1 returns the FSM to LOAD_A with `idx`=0.
- `byte_out` is 0 in every state other than OUT.
- `byte_ack` toggles on every edge accepted in LOAD_A, LOAD_B or OUT.
- Strobe edges in START or WAIT are ignored: no capture and no `byte_ack` toggle.
- `core_done` outside WAIT is ignored.
- When `ena` is low, nothing advances, including the edge register and the timeout counter.
- Asserting `rst_n` mid-operation aborts any partial load, wait or unload. Everything returns to its reset value.

## Timing
- Reset values:
  - state = LOAD_A, `idx` = 0.
  - `core_a`, `core_b`, `core_op`, `res`, `byte_out` = 0.
  - `core_start`, `busy`, `result_valid`, `err`, `byte_ack`, `stb_q` = 0.
- A byte is captured at the same clock edge where the rising edge of the strobe is first seen.
- `core_start` goes high in the cycle after the edge that captures the last byte of B.
- `core_done` sampled at edge k gives `result_valid`=1 and `byte_out`=result byte 0 after edge k.
- `byte_out` moves to the next byte one cycle after each accepted strobe edge.
- Minimum round trip is 2·NB + NB strobe edges plus core latency plus 2 cycles.

## Configuration
- `POSIT_SEQ_TIMEOUT_EN` defined: an 8-bit counter clears on entry to WAIT and increments each enabled cycle in WAIT.
  - When it reaches 255 with no `core_done`, `res` is loaded with NaR (MSB 1, all other bits 0), `err` is set and the FSM goes to OUT.
  - `err` stays set until the next START.
  - If `core_done` arrives in the same cycle as expiry, the core result is used and `err` is not set.
- `POSIT_SEQ_TIMEOUT_EN` undefined: no counter exists, WAIT holds indefinitely, and `err` is tied to 0.

## Structure
- Package `posit_io_pkg` holds:
  - the state enum (LOAD_A, LOAD_B, START, WAIT, OUT);
  - the NaR constant function of N;
  - the timeout limit constant (255).
- One sub-module, `strobe_edge_det`: the gated `stb_q` register and the edge output, with `ena` gating.

## Test plan
- Normal round trip with N=16:
  - Stimulus: strobe bytes 0x34, 0x12, 0x78, 0x56 with `op_sel`=2.
  - Required: `core_a`=0x1234, `core_b`=0x5678, `core_op`=2, and `core_start` is a single pulse.
  - Core returns 0xBEEF after 5 cycles. `byte_out` shows 0xEF, then 0xBE after one strobe, then the FSM is back in LOAD_A.
- Strobes during WAIT:
  - Stimulus: 3 strobe edges while waiting.
  - Required: `byte_ack` unchanged, operands unchanged, `byte_out` 0 until `core_done`.
- Held strobe: `byte_stb` held high for 10 cycles yields exactly one capture and one `byte_ack` toggle.
- `ena` low: `ena` held low across a strobe edge and a `core_done` pulse gives no state change, and the pending edge is seen once `ena` returns high.
- Reset mid-operation: `rst_n` pulsed low after 3 bytes loaded returns all outputs to 0, and the next 4 bytes load A and B cleanly.
- Timeout, with `POSIT_SEQ_TIMEOUT_EN` defined:
  - No `core_done` gives `err`=1 and result 0x8000 (`byte_out` 0x00, then 0x80).
  - `core_done` on the expiry cycle gives `err`=0 and the core value.
